// File: rtl/ysyx_23060191_ifu.sv
// rtl/ysyx_23060191_ifu.sv - instruction fetch unit: PC owner, single-outstanding imem initiator
module ysyx_23060191_ifu #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_addr,
    input  logic                 imem_resp_valid,
    input  logic [CPU_WIDTH-1:0] imem_resp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CPU_WIDTH-1:0] out_pc,
    output logic [CPU_WIDTH-1:0] out_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CPU_WIDTH-1:0]   pc_q;
    logic                   halted_q;
    logic                   out_valid_q;
    logic [CPU_WIDTH-1:0]   out_pc_q;
    logic [CPU_WIDTH-1:0]   out_instr_q;

    logic                   req_fire;
    logic                   out_fire;
    logic [CPU_WIDTH-1:0]   redirect_target;
    logic                   unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request is gated by rst so nothing is offered while the core is held in reset.
    assign imem_req_valid = (state_q == S_REQ) && !halted_q && !rst;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_fire       = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            if (halt) begin
                halted_q <= 1'b1;
            end

            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_q <= redirect_valid ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (redirect_valid) begin
                            state_q <= S_REQ;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_pc_q    <= pc_q;
                            out_instr_q <= imem_resp_data;
                            state_q     <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        state_q <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                    end else if (out_fire) begin
                        pc_q        <= pc_q + CPU_WIDTH'(4);
                        out_valid_q <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase

            // Redirect overrides any sequential PC update made above.
            if (redirect_valid) begin
                pc_q <= redirect_target;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// tb/tb_ysyx_23060191_ifu.sv - scoreboard bench for ysyx_23060191_ifu with random redirects and memory latency
module tb_ysyx_23060191_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    ysyx_23060191_ifu #(
        .CPU_WIDTH(32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_pc;
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          xfer_cnt = 0;
    int          last_xfer = 0;
    int          last_gap = 0;
    int          mem_lat = 1;
    bit          rand_ready = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0913;
        if (a == 32'h8000_0004) return 32'h0020_0993;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every delivered instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h, expected no delivery", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_instr", out_instr, mon_e.instr);
            end
            last_gap  = cyc_cnt - last_xfer;
            last_xfer = cyc_cnt;
            xfer_cnt++;
        end
    end

    // Reference model: delivered stream follows program order; a redirect
    // cancels whatever has not been delivered and restarts at the aligned target.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            exp_q.delete();
            model_pc = RESET_PC;
            exp_q.push_back({model_pc, mem_word(model_pc)});
        end else if (redirect_valid) begin
            exp_q.delete();
            model_pc = redirect_pc & 32'hFFFF_FFFC;
            exp_q.push_back({model_pc, mem_word(model_pc)});
        end else if (out_valid && out_ready) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back({model_pc, mem_word(model_pc)});
        end
    end

    // Protocol checker: alignment and stability of pending handshakes.
    logic        p_req = 0, p_rdy = 0, p_redir = 0, p_rst = 1, p_halt = 0, p_ov = 0, p_or = 0;
    logic [31:0] p_addr = 0, p_pc = 0, p_instr = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid) chk("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
            if (p_req && !p_rdy && !p_redir && !p_rst && !p_halt) begin
                chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
                chk("req_hold_addr", imem_addr, p_addr);
            end
            if (p_ov && !p_or && !p_redir && !p_rst) begin
                chk("out_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("out_hold_pc", out_pc, p_pc);
                chk("out_hold_instr", out_instr, p_instr);
            end
        end
        p_req = imem_req_valid; p_rdy = imem_req_ready; p_redir = redirect_valid;
        p_rst = rst; p_halt = halt; p_ov = out_valid; p_or = out_ready;
        p_addr = imem_addr; p_pc = out_pc; p_instr = out_instr;
    end

    // Memory model: one request in flight, latency mem_lat (0 = random 1..4).
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 0;
    bit          m_fire, m_rst;
    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            m_fire = imem_req_valid && imem_req_ready && !rst;
            m_rst  = rst;
            if (m_fire) begin
                chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
                mem_addr = imem_addr;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (m_rst) begin
                mem_busy = 0;
            end else if (m_fire) begin
                mem_busy = 1;
                mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(mem_addr);
                    mem_busy        = 0;
                end
            end
            imem_req_ready = rand_ready ? (($urandom % 4) != 0) : 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input string nm);
        int k = 0;
        while (!out_valid && k < 40) begin cyc(); k++; end
        if (k == 40) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req(output logic [31:0] a, input string nm);
        int k = 0;
        while (!(imem_req_valid && imem_req_ready) && k < 50) begin cyc(); k++; end
        if (k == 50) chk({nm, "_timeout"}, 32'd0, 32'd1);
        a = imem_addr;
        cyc();
    endtask

    task automatic wait_xfers(input int n, input string nm);
        int k = 0;
        while (xfer_cnt < n && k < 60) begin cyc(); k++; end
        if (k == 60) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cyc();
        redirect_valid = 1'b0;
    endtask

    logic [31:0] a, hpc, hins;
    int          base, rq;

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_addr, RESET_PC);

        // Back-to-back stream at 1-cycle latency: one instruction per 3 cycles.
        wait_xfers(3, "stream");
        chk("throughput_gap", last_gap, 32'd3);

        // Decode stall: held output stays put and no new fetch goes out.
        out_ready = 1'b0;
        wait_out("hold");
        hpc = out_pc; hins = out_instr;
        repeat (5) begin
            cyc();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_pc", out_pc, hpc);
            chk("stall_instr", out_instr, hins);
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        out_ready = 1'b1;

        // Redirect while the fetch is in flight; stale word must be dropped.
        mem_lat = 3;
        wait_req(a, "wait_issue");
        pulse_redirect(32'h8000_0103);
        wait_req(a, "wait_redirect");
        chk("redirect_wait_addr", a, 32'h8000_0100);
        wait_xfers(xfer_cnt + 1, "wait_deliver");
        mem_lat = 1;

        // Redirect coincident with delivery: delivered once, no +4.
        out_ready = 1'b0;
        wait_out("hold_redir");
        out_ready = 1'b1;
        pulse_redirect(32'h8000_0040);
        wait_req(a, "hold_redirect");
        chk("redirect_hold_addr", a, 32'h8000_0040);

        // PC wraps at the top of the address space.
        pulse_redirect(32'hFFFF_FFFF);
        wait_req(a, "wrap_a");
        chk("wrap_addr_top", a, 32'hFFFF_FFFC);
        wait_req(a, "wrap_b");
        chk("wrap_addr_zero", a, 32'h0000_0000);

        // Halt in HOLD: held instruction still delivered, then silence.
        out_ready = 1'b0;
        wait_out("hold_halt");
        base = xfer_cnt;
        halt = 1'b1; out_ready = 1'b1;
        cyc();
        halt = 1'b0;
        rq = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
            end else begin
                redirect_valid = 1'b0;
            end
            if (imem_req_valid) rq++;
            cyc();
        end
        redirect_valid = 1'b0;
        chk("halt_delivered", xfer_cnt - base, 32'd1);
        chk("halt_no_req", rq, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("restart_addr", imem_addr, RESET_PC);

        // Randomized traffic: stalls, redirects, variable latency, late halts, mid-run resets.
        rand_ready = 1'b1;
        mem_lat    = 0;
        base       = xfer_cnt;
        for (int seg = 0; seg < 4; seg++) begin
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            for (int i = 0; i < 700; i++) begin
                out_ready      = ($urandom % 4) != 0;
                redirect_valid = ($urandom % 12) == 0;
                redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
                halt           = (seg >= 2) && (($urandom % 300) == 0);
                cyc();
            end
        end
        redirect_valid = 1'b0;
        halt           = 1'b0;
        chk("random_liveness", {31'd0, (xfer_cnt - base) >= 50}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
